// File: rtl/mult_sequencer.sv
// Control sequencer for the add-shift signed multiplier: Run edge detect, N add/sub + N shift slots, done hold.
// Optional build macro MULT_CLR_ON_RUN_EN inserts a one-cycle CLR state (clear_xa pulse) at the start of each run.
module mult_sequencer #(
    parameter int N = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 ClearA_LoadB,
    input  logic                 M,
    output logic                 clr_ld,
    output logic                 clear_xa,
    output logic                 add_en,
    output logic                 sub_en,
    output logic                 shift_en,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] step
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

`ifdef MULT_CLR_ON_RUN_EN
    typedef enum logic [2:0] {IDLE = 3'd0, CLR = 3'd1, ADD = 3'd2, SHIFT = 3'd3, HOLD = 3'd4} state_t;
    localparam state_t FIRST = CLR;
`else
    typedef enum logic [2:0] {IDLE = 3'd0, ADD = 3'd2, SHIFT = 3'd3, HOLD = 3'd4} state_t;
    localparam state_t FIRST = ADD;
`endif

    state_t          state;
    logic [KW-1:0]   k;
    logic            run_q;
    logic            start;

    // run_q resets high so a Run level held through reset release is not seen as an edge
    assign start = Run & ~run_q;

    // State, iteration counter and Run history
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            k     <= '0;
            run_q <= 1'b1;
        end else begin
            run_q <= Run;
            case (state)
                IDLE: begin
                    if (start) begin
                        k     <= '0;
                        state <= FIRST;
                    end else begin
                        state <= IDLE;
                    end
                end
`ifdef MULT_CLR_ON_RUN_EN
                CLR:   state <= ADD;
`endif
                ADD:   state <= SHIFT;
                SHIFT: begin
                    if (k == K_LAST) begin
                        state <= HOLD;
                    end else begin
                        k     <= k + 1'b1;
                        state <= ADD;
                    end
                end
                HOLD: begin
                    if (!Run) begin
                        state <= IDLE;
                    end else begin
                        state <= HOLD;
                    end
                end
                default: begin
                    state <= IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

    // Datapath enables decoded from state; M selects whether the ADD slot acts
    always_comb begin
        clr_ld   = 1'b0;
        clear_xa = 1'b0;
        add_en   = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        case (state)
            IDLE: clr_ld = ClearA_LoadB & ~start & ~Reset;
`ifdef MULT_CLR_ON_RUN_EN
            CLR:  clear_xa = 1'b1;
`endif
            ADD: begin
                if (k == K_LAST) begin
                    sub_en = M;
                end else begin
                    add_en = M;
                end
            end
            SHIFT:   shift_en = 1'b1;
            HOLD:    clr_ld   = 1'b0;
            default: clr_ld   = 1'b0;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == HOLD);
    assign step = k;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed, table-driven bench for mult_sequencer (N=8); also checks async reset mid-run and Run-held-through-reset.
module tb_mult_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic       M;
    logic       clr_ld, clear_xa, add_en, sub_en, shift_en, busy, done;
    logic [2:0] step;

    int checks = 0;
    int errors = 0;

    mult_sequencer #(.N(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .clr_ld(clr_ld), .clear_xa(clear_xa), .add_en(add_en), .sub_en(sub_en),
        .shift_en(shift_en), .busy(busy), .done(done), .step(step)
    );

    always #5 Clk = ~Clk;

    // flags = {clr_ld, clear_xa, add_en, sub_en, shift_en, busy, done}
    typedef struct {
        logic       run;
        logic       clab;
        logic       m;
        logic [6:0] flags;
        logic [2:0] step;
    } vec_t;

    vec_t       vec[$];
    logic [2:0] cur_k;

    task automatic push(input logic run, input logic clab, input logic m,
                        input logic [6:0] flags, input logic [2:0] stp);
        vec_t v;
        v.run = run; v.clab = clab; v.m = m; v.flags = flags; v.step = stp;
        vec.push_back(v);
    endtask

    // One full multiply: start cycle, optional CLR, 8 ADD/SHIFT pairs, HOLD, back to IDLE
    task automatic add_run(input logic [7:0] mbits, input logic clab, input logic run_busy,
                           input int hold_cycles);
        logic a, s;
        push(1'b1, clab, mbits[0], 7'b0000000, cur_k);
`ifdef MULT_CLR_ON_RUN_EN
        push(run_busy, clab, 1'b0, 7'b0100010, 3'd0);
`endif
        for (int kk = 0; kk < 8; kk++) begin
            a = mbits[kk] && (kk < 7);
            s = mbits[kk] && (kk == 7);
            push(run_busy, clab, mbits[kk], {2'b00, a, s, 3'b010}, 3'(kk));
            push(run_busy, clab, ~mbits[kk], 7'b0000110, 3'(kk));
        end
        for (int h = 0; h < hold_cycles; h++) push(1'b1, clab, 1'b0, 7'b0000011, 3'd7);
        push(1'b0, 1'b0, 1'b0, 7'b0000011, 3'd7);
        push(1'b0, 1'b0, 1'b0, 7'b0000000, 3'd7);
        cur_k = 3'd7;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {clr_ld, clear_xa, add_en, sub_en, shift_en, busy, done, step};
    endfunction

    initial begin
        int  cnt;
        bit  found;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        cur_k = 3'd0;

        // Idle rows, then M=1 run with Run held into HOLD and ClearA_LoadB held while busy
        push(1'b0, 1'b1, 1'b1, 7'b1000000, 3'd0);
        push(1'b0, 1'b0, 1'b1, 7'b0000000, 3'd0);
        add_run(8'hFF, 1'b1, 1'b1, 3);
        push(1'b0, 1'b1, 1'b0, 7'b1000000, 3'd7);
        add_run(8'h00, 1'b0, 1'b0, 0);
        add_run(8'b1010_0110, 1'b0, 1'b1, 1);

        #2;
        check("reset_outputs", outs(), 10'd0);
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        for (int i = 0; i < vec.size(); i++) begin
            Run = vec[i].run; ClearA_LoadB = vec[i].clab; M = vec[i].m;
            @(negedge Clk);
            check($sformatf("row%0d", i), outs(), {vec[i].flags, vec[i].step});
            @(posedge Clk); #1;
        end

        // Reset asserted during SHIFT at k=3 with Run held high
        Run = 1'b1; M = 1'b1; ClearA_LoadB = 1'b0;
        found = 1'b0;
        for (cnt = 0; cnt < 40 && !found; cnt++) begin
            @(negedge Clk);
            if (shift_en && step == 3'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_shift_k3: got timeout required shift_en at step 3");
        end
        #1 Reset = 1'b1;
        #1 check("async_reset_midrun", outs(), 10'd0);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("no_start_run_held", outs(), 10'd0);
        @(posedge Clk); #1 Run = 1'b0; M = 1'b0;
        @(posedge Clk); #1 Run = 1'b1;
        @(negedge Clk);
        check("restart_start_cycle", outs(), 10'd0);
        @(posedge Clk); #1;
        check("restart_busy", {9'd0, busy}, 10'd1);

        found = 1'b0;
        for (cnt = 0; cnt < 40 && !found; cnt++) begin
            @(negedge Clk);
            if (done) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_done: got timeout required done");
        end
        check("restart_hold", outs(), {7'b0000011, 3'd7});
        @(posedge Clk); #1 Run = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        check("restart_idle", outs(), {7'b0000000, 3'd7});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
